// File: rtl/dcache_mem_bridge.sv
// Bridges dcache line write-backs and refills onto a 32-bit word memory port
// as four-beat bursts, with a per-beat ack timeout that aborts the burst.
module dcache_mem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   cpu_wen,
  input  logic [31:0]  cpu_waddr,
  input  logic [127:0] cpu_wdata,
  output logic         dev_wrdy,
  input  logic [3:0]   cpu_ren,
  input  logic [31:0]  cpu_raddr,
  output logic         dev_rrdy,
  output logic         dev_rvalid,
  output logic [127:0] dev_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         bus_err
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST, RDONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [27:0]         wline_q, wline_d;
  logic [127:0]        wbuf_q, wbuf_d;
  logic [27:0]         rline_q, rline_d;
  logic                rd_pend_q, rd_pend_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [127:0]        rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                berr_q, berr_d;
  logic                rdy_q, rdy_d;

  logic                ack;
  logic                start_rd;
  logic [27:0]         rd_line;
  logic [1:0]          beat_nx;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{cpu_waddr[3:0], cpu_raddr[3:0]};

  assign ack     = mem_ack && mem_req_q;
  assign beat_nx = beat_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    wline_d     = wline_q;
    wbuf_d      = wbuf_q;
    rline_d     = rline_q;
    rd_pend_d   = rd_pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    berr_d      = 1'b0;
    start_rd    = 1'b0;
    rd_line     = rline_q;

    case (state_q)
      IDLE: begin
        // A read left pending by an aborted write is served before new requests
        if (rd_pend_q) begin
          start_rd  = 1'b1;
          rd_pend_d = 1'b0;
        end else if (|cpu_wen) begin
          wline_d     = cpu_waddr[31:4];
          wbuf_d      = cpu_wdata;
          state_d     = WBURST;
          beat_d      = 2'd0;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {cpu_waddr[31:4], 4'b0000};
          mem_wdata_d = cpu_wdata[31:0];
          if (|cpu_ren) begin
            rline_d   = cpu_raddr[31:4];
            rd_pend_d = 1'b1;
          end
        end else if (|cpu_ren) begin
          rline_d  = cpu_raddr[31:4];
          rd_line  = cpu_raddr[31:4];
          start_rd = 1'b1;
        end
      end
      WBURST: begin
        if (ack) begin
          wait_d = '0;
          if (beat_q == 2'd3) begin
            if (rd_pend_q) begin
              start_rd  = 1'b1;
              rd_pend_d = 1'b0;
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
              mem_we_d  = 1'b0;
            end
          end else begin
            beat_d      = beat_nx;
            mem_addr_d  = {wline_q, beat_nx, 2'b00};
            mem_wdata_d = wbuf_q[{beat_nx, 5'b00000} +: 32];
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wait_d    = '0;
          berr_d    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RBURST: begin
        if (ack) begin
          wait_d = '0;
          rdata_d[{beat_q, 5'b00000} +: 32] = mem_rdata;
          if (beat_q == 2'd3) begin
            state_d   = RDONE;
            mem_req_d = 1'b0;
            rvalid_d  = 1'b1;
          end else begin
            beat_d     = beat_nx;
            mem_addr_d = {rline_q, beat_nx, 2'b00};
          end
        end else if (wait_q == WAIT_LAST) begin
          // Aborted refill still completes upstream, with an all-zero line
          state_d   = RDONE;
          mem_req_d = 1'b0;
          wait_d    = '0;
          rdata_d   = '0;
          rvalid_d  = 1'b1;
          berr_d    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_rd) begin
      state_d    = RBURST;
      beat_d     = 2'd0;
      wait_d     = '0;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = {rd_line, 4'b0000};
    end

    rdy_d = (state_d == IDLE) && !rd_pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      wait_q      <= '0;
      wline_q     <= '0;
      wbuf_q      <= '0;
      rline_q     <= '0;
      rd_pend_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      berr_q      <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      wline_q     <= wline_d;
      wbuf_q      <= wbuf_d;
      rline_q     <= rline_d;
      rd_pend_q   <= rd_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      berr_q      <= berr_d;
      rdy_q       <= rdy_d;
    end
  end

  // Ready flop resets high so the bridge is ready the moment reset releases
  assign dev_wrdy   = rdy_q && !rst;
  assign dev_rrdy   = rdy_q && !rst;
  assign dev_rvalid = rvalid_q;
  assign dev_rdata  = rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign bus_err    = berr_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: word-memory responder with programmable
// ack latency, beat log, and immediate-assertion checks on each step.
module tb_dcache_mem_bridge;

  logic         clk;
  logic         rst;
  logic [3:0]   cpu_wen;
  logic [31:0]  cpu_waddr;
  logic [127:0] cpu_wdata;
  logic         dev_wrdy;
  logic [3:0]   cpu_ren;
  logic [31:0]  cpu_raddr;
  logic         dev_rrdy;
  logic         dev_rvalid;
  logic [127:0] dev_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         bus_err;

  dcache_mem_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .dev_wrdy(dev_wrdy),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .dev_rrdy(dev_rrdy),
    .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Responder and beat log
  int          ack_lat = 0;
  int          wcnt = 0;
  int          log_n = 0;
  logic        log_we [0:15];
  logic [31:0] log_addr [0:15];
  logic [31:0] log_wdata [0:15];
  int          rvalid_cnt = 0;
  int          berr_cnt = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dev_rvalid) rvalid_cnt++;
      if (bus_err) berr_cnt++;
      if (mem_req && ack_lat >= 0 && wcnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ 32'hA5A5_A5A5;
        if (log_n < 16) begin
          log_we[log_n]    = mem_we;
          log_addr[log_n]  = mem_addr;
          log_wdata[log_n] = mem_wdata;
          log_n++;
        end
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = mem_req ? wcnt + 1 : 0;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = (base + 32'(4*k)) ^ 32'hA5A5_A5A5;
    return l;
  endfunction

  // Called at a negedge; returns at the negedge of the first burst cycle
  task automatic issue(input logic [3:0] wen, input logic [31:0] waddr, input logic [127:0] wdata,
                       input logic [3:0] ren, input logic [31:0] raddr);
    cpu_wen = wen; cpu_waddr = waddr; cpu_wdata = wdata;
    cpu_ren = ren; cpu_raddr = raddr;
    @(negedge clk);
    cpu_wen = '0; cpu_ren = '0;
  endtask

  task automatic wait_rvalid(input int budget, output int cyc);
    cyc = 0;
    while (!dev_rvalid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("rvalid_seen", 128'(dev_rvalid), 128'd1);
  endtask

  task automatic clear_log();
    log_n = 0; rvalid_cnt = 0; berr_cnt = 0;
  endtask

  int cyc;
  int req_low;

  initial begin
    rst = 1'b1;
    cpu_wen = '0; cpu_waddr = '0; cpu_wdata = '0;
    cpu_ren = '0; cpu_raddr = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_req",   128'(mem_req),    128'd0);
    check("rst_mem_we",    128'(mem_we),     128'd0);
    check("rst_mem_addr",  128'(mem_addr),   128'd0);
    check("rst_mem_wdata", 128'(mem_wdata),  128'd0);
    check("rst_dev_rdata", dev_rdata,        128'd0);
    check("rst_rvalid",    128'(dev_rvalid), 128'd0);
    check("rst_bus_err",   128'(bus_err),    128'd0);
    check("rst_wrdy",      128'(dev_wrdy),   128'd0);
    check("rst_rrdy",      128'(dev_rrdy),   128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_wrdy", 128'(dev_wrdy), 128'd1);
    check("post_rst_rrdy", 128'(dev_rrdy), 128'd1);
    @(negedge clk);

    // Zero-wait read
    ack_lat = 0; clear_log();
    issue(4'h0, 32'h0, 128'h0, 4'hF, 32'h0000_1238);
    check("a_rrdy_busy", 128'(dev_rrdy), 128'd0);
    wait_rvalid(20, cyc);
    check("a_rvalid_lat", 128'(cyc), 128'd4);
    check("a_beats", 128'(log_n), 128'd4);
    check("a_addr0", 128'(log_addr[0]), 128'h1230);
    check("a_addr1", 128'(log_addr[1]), 128'h1234);
    check("a_addr2", 128'(log_addr[2]), 128'h1238);
    check("a_addr3", 128'(log_addr[3]), 128'h123C);
    check("a_we", 128'({log_we[0], log_we[1], log_we[2], log_we[3]}), 128'd0);
    check("a_rdata", dev_rdata, 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795);
    @(negedge clk);
    check("a_rvalid_once", 128'(rvalid_cnt), 128'd1);
    check("a_rvalid_low", 128'(dev_rvalid), 128'd0);
    check("a_wrdy_back", 128'(dev_wrdy), 128'd1);
    check("a_rdata_hold", dev_rdata, 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795);

    // Write-back with 2-cycle ack latency
    ack_lat = 2; clear_log();
    issue(4'hF, 32'h0000_0080, 128'h44444444_33333333_22222222_11111111, 4'h0, 32'h0);
    cyc = 0; req_low = 0;
    while (!dev_wrdy && cyc < 50) begin
      if (!mem_req) req_low++;
      @(negedge clk);
      cyc++;
    end
    check("b_cycles", 128'(cyc), 128'd12);
    check("b_req_gap", 128'(req_low), 128'd0);
    check("b_beats", 128'(log_n), 128'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b_we%0d", k), 128'(log_we[k]), 128'd1);
      check($sformatf("b_addr%0d", k), 128'(log_addr[k]), 128'(32'h80 + 32'(4*k)));
      check($sformatf("b_wdata%0d", k), 128'(log_wdata[k]), 128'({4{8'(k+1) * 8'h11}}));
    end
    check("b_no_rvalid", 128'(rvalid_cnt), 128'd0);
    check("b_mem_req_low", 128'(mem_req), 128'd0);

    // Same-cycle write-back and refill
    ack_lat = 1; clear_log();
    issue(4'h3, 32'h0000_0204, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4'h1, 32'h0000_030C);
    wait_rvalid(60, cyc);
    repeat (2) @(negedge clk);
    check("c_beats", 128'(log_n), 128'd8);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("c_wwe%0d", k), 128'(log_we[k]), 128'd1);
      check($sformatf("c_waddr%0d", k), 128'(log_addr[k]), 128'(32'h200 + 32'(4*k)));
      check($sformatf("c_rwe%0d", k), 128'(log_we[k+4]), 128'd0);
      check($sformatf("c_raddr%0d", k), 128'(log_addr[k+4]), 128'(32'h300 + 32'(4*k)));
    end
    check("c_wdata0", 128'(log_wdata[0]), 128'hAAAAAAAA);
    check("c_wdata3", 128'(log_wdata[3]), 128'hDDDDDDDD);
    check("c_rvalid_once", 128'(rvalid_cnt), 128'd1);
    check("c_rdata", dev_rdata, exp_line(32'h300));
    check("c_wdata_kept", 128'(mem_wdata), 128'hDDDDDDDD);
    check("c_wrdy", 128'(dev_wrdy), 128'd1);

    // Read timeout: no ack ever
    ack_lat = -1; clear_log();
    issue(4'h0, 32'h0, 128'h0, 4'h8, 32'h0000_4000);
    cyc = 0;
    while (!bus_err && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("d_berr_seen", 128'(bus_err), 128'd1);
    check("d_wait_cycles", 128'(cyc), 128'd8);
    check("d_req_dropped", 128'(mem_req), 128'd0);
    check("d_rvalid", 128'(dev_rvalid), 128'd1);
    check("d_rdata_zero", dev_rdata, 128'd0);
    @(negedge clk);
    check("d_berr_pulse", 128'(bus_err), 128'd0);
    check("d_rvalid_pulse", 128'(dev_rvalid), 128'd0);
    check("d_idle", 128'(dev_wrdy), 128'd1);
    check("d_counts", 128'({berr_cnt[7:0], rvalid_cnt[7:0]}), 128'h0101);

    // Reset after the 2nd read ack, then a clean read
    ack_lat = 0; clear_log();
    issue(4'h0, 32'h0, 128'h0, 4'hF, 32'h0000_0500);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("e_req_killed", 128'(mem_req), 128'd0);
    check("e_wrdy_rst", 128'(dev_wrdy), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("e_wrdy_after", 128'(dev_wrdy), 128'd1);
    repeat (6) @(negedge clk);
    check("e_no_rvalid", 128'(rvalid_cnt), 128'd0);
    check("e_no_berr", 128'(berr_cnt), 128'd0);
    check("e_rdata_rst", dev_rdata, 128'd0);
    clear_log();
    issue(4'h0, 32'h0, 128'h0, 4'h2, 32'h0000_0600);
    wait_rvalid(20, cyc);
    check("e_lat", 128'(cyc), 128'd4);
    check("e_rdata", dev_rdata, exp_line(32'h600));
    check("e_beats", 128'(log_n), 128'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_mem_bridge.md
DCACHE_MEM_BRIDGE -- requirements
Module: dcache_mem_bridge

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter: TIMEOUT_CYC, 1023, max cycles mem_req may wait for mem_ack before abort.
REQ-003 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- cpu_wen  in  4  line write-back request from dcache; nonzero = request, one-cycle pulse.
- cpu_waddr  in  32  write-back address; bits [3:0] ignored.
- cpu_wdata  in  128  write-back line; word k = bits [32k+31:32k].
- dev_wrdy  out  1  bridge can accept a write-back.
- cpu_ren  in  4  line refill request; nonzero = request, one-cycle pulse.
- cpu_raddr  in  32  refill address; bits [3:0] ignored.
- dev_rrdy  out  1  bridge can accept a refill.
- dev_rvalid  out  1  one-cycle pulse, refill line on dev_rdata.
- dev_rdata  out  128  refill line; word k = bits [32k+31:32k].
- mem_req  out  1  word-memory request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  word address, bits [1:0] = 0.
- mem_wdata  out  32  write beat data.
- mem_ack  in  1  beat complete; mem_rdata valid this cycle for reads.
- mem_rdata  in  32  read beat data.
- bus_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-004 SHALL implement states IDLE, WBURST, RBURST, RDONE.
REQ-005 SHALL drive dev_wrdy = dev_rrdy = 1 only in IDLE with no pending request latched.
REQ-006 SHALL, in IDLE on an edge with cpu_wen != 0, latch {cpu_waddr[31:4], cpu_wdata} and enter WBURST next cycle.
REQ-007 SHALL, in IDLE on an edge with cpu_ren != 0, latch cpu_raddr[31:4] and enter RBURST. If cpu_wen is also nonzero, RBURST is entered only after WBURST ends.
REQ-008 SHALL ignore cpu_wen/cpu_ren outside IDLE.
REQ-009 SHALL issue four beats k = 0,1,2,3 in order, with mem_addr = {line[31:4], k[1:0], 2'b00}. For writes, mem_wdata = word k.
REQ-010 SHALL drive mem_req, mem_we, mem_addr and mem_wdata from registers.
- mem_req is held high continuously from beat 0 until the ack of beat 3.
- Address and data advance on the edge after each ack.
- Ack in the same cycle mem_req rises is legal (zero-wait).
REQ-011 SHALL ignore mem_ack while mem_req = 0.
REQ-012 SHALL store mem_rdata of read beat k into dev_rdata word k on the acking edge.
REQ-013 SHALL, after beat 3 ack of a write, return to IDLE, or go to RBURST if a read is pending. No upstream write acknowledge exists.
REQ-014 SHALL, after beat 3 ack of a read, enter RDONE for exactly one cycle with dev_rvalid = 1, then enter IDLE.
REQ-015 SHALL hold dev_rdata stable from RDONE until the next read burst's beat 0 ack.
REQ-016 SHALL use a wait counter that clears on each ack and on burst start, and increments each cycle mem_req = 1 without ack.
REQ-017 SHALL, when the wait counter reaches TIMEOUT_CYC, abort the burst:
- mem_req drops next cycle and bus_err pulses one cycle.
- Read abort: dev_rdata is set to 0 and RDONE is entered, so dev_rvalid still pulses.
- Write abort: the line is dropped and a pending read is still served.
REQ-018 SHALL keep mem_we = 0 and mem_wdata unchanged in RBURST.

Reset
REQ-019 SHALL, while rst = 1, force state IDLE, beat counter 0, wait counter 0, and pending flags 0.
REQ-020 SHALL, while rst = 1, force outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, dev_rdata = 0, dev_rvalid = 0, bus_err = 0, dev_wrdy = dev_rrdy = 0.
REQ-021 SHALL assert dev_wrdy = dev_rrdy = 1 in the first cycle after rst deasserts.
REQ-022 SHALL, on reset mid-burst, abandon the burst with no dev_rvalid or bus_err emitted.

Verification
REQ-023 Zero-wait read: cpu_ren = 4'hF, cpu_raddr = 0x0000_1238, mem_rdata = addr ^ 0xA5A5A5A5 -> mem_addr 0x1230/34/38/3C on consecutive cycles; dev_rvalid pulses once, one cycle after the 4th ack; dev_rdata word k = (0x1230 + 4k) ^ 0xA5A5A5A5.
REQ-024 Write-back with 2-cycle ack latency: cpu_wdata = 0x44444444_33333333_22222222_11111111, addr 0x80 -> writes 0x11111111 @0x80 through 0x44444444 @0x8C, mem_req continuous, dev_wrdy low throughout, high after the last ack.
REQ-025 Same-cycle cpu_wen and cpu_ren -> four write beats followed by four read beats, exactly one dev_rvalid, no request lost.
REQ-026 TIMEOUT_CYC = 8, mem_ack never asserted on a read -> bus_err pulse after 8 waiting cycles, dev_rvalid pulse with dev_rdata = 0, return to IDLE.
REQ-027 rst asserted after the 2nd read ack -> mem_req = 0 immediately, no dev_rvalid; a new read after reset completes normally.
